// File: rtl/mfilter_coeff_loader.sv
// mfilter_coeff_loader
//   Configuration front end for the inband matched filter. Serial-bus writes
//   fill a shadow bank (12 tap words, a threshold) and a commit in the control
//   register checks that bank and copies it into the active bank, which drives
//   the filter. The active outputs only change on the edge that enters SWAP.
//   co_valid drops on that same edge and returns one cycle later, so the filter
//   never sees co_valid high while the taps are changing.
//
// Parameters
//   BASE_ADDR  serial address of CTRL; THRESH at +1, tap words at +2..+13
//   MAX_TAPS   largest accepted commit length
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   serial_strobe/addr/data one-cycle register write
//   co_0 .. co_11           active tap words (2 bits per tap, 16 taps per word)
//   co_length               active tap count
//   co_valid                active bank is consistent and usable
//   threshold               active match threshold
//   cfg_err                 sticky: last commit was rejected
//   debugbus                {state[1:0], cfg_err, co_valid, wr_mask[11:0]}
//   rb_addr, rb_data        register readback, only with COEFF_READBACK_EN
//
// Build option
//   COEFF_READBACK_EN  adds the rb_addr/rb_data readback port (1-cycle latency)

module mfilter_coeff_loader #(
  parameter logic [6:0] BASE_ADDR = 7'd64,
  parameter int         MAX_TAPS  = 192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        serial_strobe,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  output logic [31:0] co_0,
  output logic [31:0] co_1,
  output logic [31:0] co_2,
  output logic [31:0] co_3,
  output logic [31:0] co_4,
  output logic [31:0] co_5,
  output logic [31:0] co_6,
  output logic [31:0] co_7,
  output logic [31:0] co_8,
  output logic [31:0] co_9,
  output logic [31:0] co_10,
  output logic [31:0] co_11,
  output logic [7:0]  co_length,
  output logic        co_valid,
  output logic [31:0] threshold,
  output logic        cfg_err,
  output logic [15:0] debugbus
`ifdef COEFF_READBACK_EN
  ,
  input  logic [3:0]  rb_addr,
  output logic [31:0] rb_data
`endif
);

  localparam logic [8:0] MAX_LEN = 9'(MAX_TAPS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    SWAP   = 2'd2
  } state_t;

  state_t      state, state_next;

  logic [31:0] shadow_word [12];
  logic [31:0] shadow_thresh;
  logic [31:0] active_word [12];
  logic [11:0] wr_mask, wr_mask_next;
  logic        co_valid_next;
  logic        cfg_err_next;

  // Words 0..ceil(len/16)-1 must have been written since the last commit.
  function automatic logic [11:0] required_mask(input logic [7:0] len);
    logic [8:0]  rounded;
    logic [4:0]  words;
    logic [12:0] mask;
    rounded = {1'b0, len} + 9'd15;
    words   = rounded[8:4];
    mask    = (13'd1 << words) - 13'd1;
    return mask[11:0];
  endfunction

  // Address decode; 8-bit arithmetic keeps addresses below BASE_ADDR out of range
  logic [7:0] addr_ext, base_ext, offset;
  logic       addr_hit;
  logic       wr_ctrl, wr_thresh, wr_word;
  logic [3:0] word_idx;

  always_comb begin
    addr_ext  = {1'b0, serial_addr};
    base_ext  = {1'b0, BASE_ADDR};
    offset    = addr_ext - base_ext;
    addr_hit  = (addr_ext >= base_ext) && (offset < 8'd14);
    wr_ctrl   = serial_strobe && addr_hit && (offset == 8'd0);
    wr_thresh = serial_strobe && addr_hit && (offset == 8'd1);
    wr_word   = serial_strobe && addr_hit && (offset >= 8'd2);
    word_idx  = offset[3:0] - 4'd2;
  end

  // Control register fields and commit qualification
  logic       ctrl_clear, ctrl_commit;
  logic [7:0] ctrl_len;
  logic       len_ok, mask_ok;
  logic       do_clear, commit_ok, commit_bad;

  always_comb begin
    ctrl_clear  = serial_data[9];
    ctrl_commit = serial_data[8];
    ctrl_len    = serial_data[7:0];
    len_ok      = (ctrl_len != 8'd0) && ({1'b0, ctrl_len} <= MAX_LEN);
    mask_ok     = (wr_mask & required_mask(ctrl_len)) == required_mask(ctrl_len);
    do_clear    = wr_ctrl && ctrl_clear;
    // Clear overrides commit, and such a write leaves cfg_err alone.
    commit_ok   = wr_ctrl && ctrl_commit && !ctrl_clear && len_ok && mask_ok;
    commit_bad  = wr_ctrl && ctrl_commit && !ctrl_clear && !(len_ok && mask_ok);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state and control register updates
  always_comb begin
    state_next    = state;
    co_valid_next = co_valid;
    cfg_err_next  = cfg_err;
    wr_mask_next  = wr_mask;

    case (state)
      IDLE, ACTIVE: begin
        if (do_clear)       state_next = IDLE;
        else if (commit_ok) state_next = SWAP;
      end
      SWAP: begin
        if (do_clear)       state_next = IDLE;
        else if (commit_ok) state_next = SWAP;
        else                state_next = ACTIVE;
      end
      default: state_next = IDLE;
    endcase

    // Valid follows the bank: low across the transfer, high once it has settled.
    if (do_clear || commit_ok) co_valid_next = 1'b0;
    else if (state == SWAP)    co_valid_next = 1'b1;

    if (commit_ok)       cfg_err_next = 1'b0;
    else if (commit_bad) cfg_err_next = 1'b1;

    // Mask restarts on an accepted commit; a shadow write can only arrive on a
    // later strobe, so writes during SWAP are always recorded.
    if (do_clear || commit_ok) wr_mask_next = 12'd0;
    if (wr_word) wr_mask_next[word_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      co_valid      <= 1'b0;
      cfg_err       <= 1'b0;
      wr_mask       <= 12'd0;
      shadow_thresh <= 32'd0;
      threshold     <= 32'd0;
      co_length     <= 8'd0;
      for (int k = 0; k < 12; k++) begin
        shadow_word[k] <= 32'd0;
        active_word[k] <= 32'd0;
      end
    end else begin
      co_valid <= co_valid_next;
      cfg_err  <= cfg_err_next;
      wr_mask  <= wr_mask_next;
      if (wr_thresh) shadow_thresh <= serial_data;
      if (wr_word)   shadow_word[word_idx] <= serial_data;
      // Bank transfer happens on the edge entering SWAP, while co_valid drops.
      if (commit_ok) begin
        threshold <= shadow_thresh;
        co_length <= ctrl_len;
        for (int k = 0; k < 12; k++) active_word[k] <= shadow_word[k];
      end
    end
  end

  assign co_0  = active_word[0];
  assign co_1  = active_word[1];
  assign co_2  = active_word[2];
  assign co_3  = active_word[3];
  assign co_4  = active_word[4];
  assign co_5  = active_word[5];
  assign co_6  = active_word[6];
  assign co_7  = active_word[7];
  assign co_8  = active_word[8];
  assign co_9  = active_word[9];
  assign co_10 = active_word[10];
  assign co_11 = active_word[11];

  assign debugbus = {state, cfg_err, co_valid, wr_mask};

`ifdef COEFF_READBACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rb_data <= 32'd0;
    end else begin
      case (rb_addr)
        4'd12:   rb_data <= {co_length, 23'd0, co_valid};
        4'd13:   rb_data <= threshold;
        4'd14:   rb_data <= {20'd0, wr_mask};
        4'd15:   rb_data <= 32'd0;
        default: rb_data <= active_word[rb_addr];
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_mfilter_coeff_loader.sv
// Directed bench for mfilter_coeff_loader: stimulus on the falling edge,
// outputs sampled on the falling edge after each rising edge.
module tb_mfilter_coeff_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        serial_strobe;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic [31:0] co [12];
  logic [7:0]  co_length;
  logic        co_valid;
  logic [31:0] threshold;
  logic        cfg_err;
  logic [15:0] debugbus;
`ifdef COEFF_READBACK_EN
  logic [3:0]  rb_addr = 4'd0;
  logic [31:0] rb_data;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] CTRL   = 7'd64;
  localparam logic [6:0] THRESH = 7'd65;
  localparam logic [6:0] WORD0  = 7'd66;

  always #5 clk = ~clk;

  mfilter_coeff_loader dut (
    .clk(clk), .reset(reset),
    .serial_strobe(serial_strobe), .serial_addr(serial_addr), .serial_data(serial_data),
    .co_0(co[0]), .co_1(co[1]), .co_2(co[2]), .co_3(co[3]),
    .co_4(co[4]), .co_5(co[5]), .co_6(co[6]), .co_7(co[7]),
    .co_8(co[8]), .co_9(co[9]), .co_10(co[10]), .co_11(co[11]),
    .co_length(co_length), .co_valid(co_valid), .threshold(threshold),
    .cfg_err(cfg_err), .debugbus(debugbus)
`ifdef COEFF_READBACK_EN
    , .rb_addr(rb_addr), .rb_data(rb_data)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One strobe; returns on the falling edge after the capturing rising edge.
  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    serial_strobe = 1'b1;
    serial_addr   = a;
    serial_data   = d;
    @(negedge clk);
    serial_strobe = 1'b0;
  endtask

  initial begin
    reset = 1'b1; serial_strobe = 1'b0; serial_addr = 7'd0; serial_data = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_valid",  {31'd0, co_valid}, 32'd0);
    check("rst_length", {24'd0, co_length}, 32'd0);
    check("rst_co0",    co[0], 32'd0);
    check("rst_co11",   co[11], 32'd0);
    check("rst_thresh", threshold, 32'd0);
    check("rst_cfgerr", {31'd0, cfg_err}, 32'd0);
    check("rst_debug",  {16'd0, debugbus}, 32'h0000);

    // First commit, length 32
    wr(WORD0 + 7'd0, 32'hA5A5_0F0F);
    wr(WORD0 + 7'd1, 32'h1234_5678);
    wr(THRESH, 32'd500);
    check("mask_01", {16'd0, debugbus}, 32'h0003);
    wr(CTRL, 32'h0000_0120);
    check("swap_valid",  {31'd0, co_valid}, 32'd0);
    check("swap_length", {24'd0, co_length}, 32'd32);
    check("swap_co1",    co[1], 32'h1234_5678);
    check("swap_thresh", threshold, 32'd500);
    check("swap_debug",  {16'd0, debugbus}, 32'h8000);
    @(negedge clk);
    check("act_valid", {31'd0, co_valid}, 32'd1);
    check("act_co0",   co[0], 32'hA5A5_0F0F);
    check("act_debug", {16'd0, debugbus}, 32'h5000);

    // Length 40 needs word 2: rejected, bank untouched
    wr(WORD0 + 7'd0, 32'h0000_0001);
    wr(WORD0 + 7'd1, 32'h0000_0002);
    wr(CTRL, 32'h0000_0128);
    check("rej40_cfgerr", {31'd0, cfg_err}, 32'd1);
    check("rej40_length", {24'd0, co_length}, 32'd32);
    check("rej40_co0",    co[0], 32'hA5A5_0F0F);
    check("rej40_debug",  {16'd0, debugbus}, 32'h7003);

    // Clear + commit in one write: clear wins, cfg_err kept
    wr(CTRL, 32'h0000_0310);
    check("clr_valid", {31'd0, co_valid}, 32'd0);
    check("clr_debug", {16'd0, debugbus}, 32'h2000);
    check("clr_co1",   co[1], 32'h1234_5678);
    check("clr_len",   {24'd0, co_length}, 32'd32);

    // Full 192-tap bank
    for (int k = 0; k < 12; k++) wr(WORD0 + 7'(k), 32'h1000_0000 + 32'(k));
    check("mask_all", {16'd0, debugbus}, 32'h2FFF);
    wr(CTRL, 32'h0000_01C0);
    check("c192_valid0", {31'd0, co_valid}, 32'd0);
    check("c192_co11",   co[11], 32'h1000_000B);
    check("c192_cfgerr", {31'd0, cfg_err}, 32'd0);
    @(negedge clk);
    check("c192_valid1", {31'd0, co_valid}, 32'd1);
    check("c192_length", {24'd0, co_length}, 32'd192);

    // Length 193 rejected
    wr(CTRL, 32'h0000_01C1);
    check("rej193_cfgerr", {31'd0, cfg_err}, 32'd1);
    check("rej193_length", {24'd0, co_length}, 32'd192);
    check("rej193_valid",  {31'd0, co_valid}, 32'd1);

    // Commit 16, then write word 3 during the SWAP cycle
    wr(WORD0 + 7'd0, 32'h2222_0000);
    wr(CTRL, 32'h0000_0110);
    wr(WORD0 + 7'd3, 32'hDEAD_BEEF);
    check("sw3_co3",    co[3], 32'h1000_0003);
    check("sw3_co0",    co[0], 32'h2222_0000);
    check("sw3_length", {24'd0, co_length}, 32'd16);
    check("sw3_debug",  {16'd0, debugbus}, 32'h5008);

    // Length 0 rejected
    wr(CTRL, 32'h0000_0100);
    check("rej0_cfgerr", {31'd0, cfg_err}, 32'd1);
    check("rej0_length", {24'd0, co_length}, 32'd16);

    // Reset asserted during SWAP
    wr(WORD0 + 7'd0, 32'h3333_0000);
    wr(CTRL, 32'h0000_0110);
    check("rsw_valid0", {31'd0, co_valid}, 32'd0);
    check("rsw_co0pre", co[0], 32'h3333_0000);
    reset = 1'b1;
    @(negedge clk);
    check("rsw_valid",  {31'd0, co_valid}, 32'd0);
    check("rsw_length", {24'd0, co_length}, 32'd0);
    check("rsw_co0",    co[0], 32'd0);
    check("rsw_co3",    co[3], 32'd0);
    check("rsw_thresh", threshold, 32'd0);
    check("rsw_debug",  {16'd0, debugbus}, 32'h0000);
    reset = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
